// File: rtl/sync_debounce_if.sv
// Debouncer bus: sample enable and synchronised level in; debounced level,
// edge pulses and accepted-edge count out.
interface sync_debounce_if #(
    parameter int EW = 8
);
    logic          ce;
    logic          i;
    logic          o;
    logic          rise;
    logic          fall;
    logic [EW-1:0] edges;

    modport master (output ce, i, input o, rise, fall, edges);
    modport slave  (input ce, i, output o, rise, fall, edges);
endinterface

// File: rtl/sync_debounce.sv
// Debounces an already-synchronised level: the output follows the input only
// after HOLD consecutive enabled samples that disagree with the current output.
module sync_debounce #(
    parameter int HOLD  = 1000,
    parameter int CNT_W = 16,
    parameter int EW    = 8,
    parameter bit INIT  = 1'b0
) (
    input  logic            c,
    input  logic            rst_n,
    sync_debounce_if.slave  bus
);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

    generate
        if ((HOLD < 1) || (longint'(HOLD) > (longint'(1) << CNT_W))) begin : g_bad_hold
            $error("sync_debounce: HOLD=%0d outside 1..2**CNT_W", HOLD);
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             o_q, o_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [EW-1:0]    edges_q, edges_d;

    // Agreement with the output always clears the count, even when ce is low,
    // so a bounce during a disabled sample still restarts qualification.
    always_comb begin
        cnt_d   = cnt_q;
        o_d     = o_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        edges_d = edges_q;
        if (bus.i == o_q) begin
            cnt_d = '0;
        end else if (bus.ce) begin
            if (cnt_q == HOLD_M1) begin
                o_d     = bus.i;
                cnt_d   = '0;
                rise_d  = bus.i;
                fall_d  = ~bus.i;
                edges_d = edges_q + EW'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            o_q     <= INIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            edges_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            edges_q <= edges_d;
        end
    end

    assign bus.o     = o_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.edges = edges_q;
endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: three instances (HOLD=4, HOLD=1, INIT=1) share one
// stimulus stream and are compared against a run-length reference model.
module tb_sync_debounce;
    logic c = 1'b0;
    logic rst_n = 1'b0;
    logic ce_s = 1'b1;
    logic i_s = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 c = ~c;

    sync_debounce_if #(.EW(4)) bus4 ();
    sync_debounce_if #(.EW(4)) bus1 ();
    sync_debounce_if #(.EW(4)) busi ();

    assign bus4.ce = ce_s;
    assign bus4.i  = i_s;
    assign bus1.ce = ce_s;
    assign bus1.i  = i_s;
    assign busi.ce = ce_s;
    assign busi.i  = i_s;

    sync_debounce #(.HOLD(4), .CNT_W(4), .EW(4), .INIT(1'b0)) dut4 (.c(c), .rst_n(rst_n), .bus(bus4));
    sync_debounce #(.HOLD(1), .CNT_W(4), .EW(4), .INIT(1'b0)) dut1 (.c(c), .rst_n(rst_n), .bus(bus1));
    sync_debounce #(.HOLD(4), .CNT_W(4), .EW(4), .INIT(1'b1)) duti (.c(c), .rst_n(rst_n), .bus(busi));

    localparam int HOLDS [3] = '{4, 1, 4};
    localparam bit INITS [3] = '{1'b0, 1'b0, 1'b1};

    // Reference: count qualifying samples; when the run reaches HOLD the output flips.
    logic m_o [3];
    logic m_rise [3];
    logic m_fall [3];
    int   m_run [3];
    int   m_edges [3];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_o[k] = INITS[k]; m_rise[k] = 1'b0; m_fall[k] = 1'b0;
            m_run[k] = 0; m_edges[k] = 0;
        end
    endfunction

    function automatic void model_step(input logic ce_v, input logic i_v);
        for (int k = 0; k < 3; k++) begin
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (i_v == m_o[k]) m_run[k] = 0;
            else if (ce_v) begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] == HOLDS[k]) begin
                    m_o[k] = i_v; m_rise[k] = i_v; m_fall[k] = ~i_v;
                    m_edges[k] = (m_edges[k] + 1) % 16;
                    m_run[k] = 0;
                end
            end
        end
    endfunction

    function automatic logic [6:0] obs(input int k);
        case (k)
            0:       return {bus4.o, bus4.rise, bus4.fall, bus4.edges};
            1:       return {bus1.o, bus1.rise, bus1.fall, bus1.edges};
            default: return {busi.o, busi.rise, busi.fall, busi.edges};
        endcase
    endfunction

    function automatic logic [6:0] expv(input int k);
        return {m_o[k], m_rise[k], m_fall[k], 4'(m_edges[k])};
    endfunction

    task automatic tick(input logic ce_v, input logic i_v);
        ce_s = ce_v;
        i_s  = i_v;
        @(posedge c);
        model_step(ce_v, i_v);
        @(negedge c);
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge c);
        rst_n = 1'b0;
        model_reset();
        @(negedge c);
        rst_n = 1'b1;
        ce_s = 1'b1;
        i_s = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge c);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs(k) !== expv(k)) begin
                miscompares++;
                $display("FAIL reset dut%0d: got o/r/f/e=%b required %b", k, obs(k), expv(k));
            end
        end
        vectors++;
        if (busi.o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_init1: got o=%b required 1", busi.o);
        end
        @(negedge c);
        rst_n = 1'b1;
    endtask

    task automatic test_rise();
        apply_reset();
        for (int n = 1; n <= 5; n++) begin
            tick(1'b1, 1'b1);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs(k) !== expv(k)) begin
                    miscompares++;
                    $display("FAIL rise dut%0d cyc%0d: got %b required %b", k, cyc, obs(k), expv(k));
                end
            end
            vectors++;
            if ({bus4.o, bus4.rise} !== ((n < 4) ? 2'b00 : (n == 4) ? 2'b11 : 2'b10)) begin
                miscompares++;
                $display("FAIL rise_latency n=%0d: got o,rise=%b%b", n, bus4.o, bus4.rise);
            end
        end
        vectors++;
        if (bus4.edges !== 4'd1) begin
            miscompares++;
            $display("FAIL rise_edges: got %0d required 1", bus4.edges);
        end
    endtask

    task automatic test_glitch();
        logic [6:0] pat;
        logic       hit;
        pat = 7'b1110111;
        hit = 1'b0;
        apply_reset();
        for (int n = 6; n >= 0; n--) begin
            tick(1'b1, pat[n]);
            hit = hit | bus4.rise;
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs(k) !== expv(k)) begin
                    miscompares++;
                    $display("FAIL glitch dut%0d cyc%0d: got %b required %b", k, cyc, obs(k), expv(k));
                end
            end
        end
        vectors++;
        if ({bus4.o, hit, bus4.edges} !== 6'b0) begin
            miscompares++;
            $display("FAIL glitch_reject: got o=%b rise_seen=%b edges=%0d required 0,0,0", bus4.o, hit, bus4.edges);
        end
    endtask

    task automatic test_fall();
        int fall_cycles;
        fall_cycles = 0;
        apply_reset();
        for (int n = 0; n < 10; n++) begin
            tick(1'b1, (n < 4));
            if (n >= 4) fall_cycles += int'(bus4.fall);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs(k) !== expv(k) || (obs(k) & 7'b0110000) == 7'b0110000) begin
                    miscompares++;
                    $display("FAIL fall dut%0d cyc%0d: got %b required %b", k, cyc, obs(k), expv(k));
                end
            end
        end
        vectors++;
        if (fall_cycles != 1 || bus4.o !== 1'b0 || bus4.edges !== 4'd2) begin
            miscompares++;
            $display("FAIL fall_once: got fall_cycles=%0d o=%b edges=%0d required 1,0,2", fall_cycles, bus4.o, bus4.edges);
        end
    endtask

    task automatic test_ce();
        logic [10:0] ce_pat;
        logic [10:0] i_pat;
        apply_reset();
        for (int n = 1; n <= 7; n++) begin
            tick((n % 2) == 1, 1'b1);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs(k) !== expv(k)) begin
                    miscompares++;
                    $display("FAIL ce dut%0d cyc%0d: got %b required %b", k, cyc, obs(k), expv(k));
                end
            end
            vectors++;
            if (bus4.o !== (n == 7)) begin
                miscompares++;
                $display("FAIL ce_latency n=%0d: got o=%b required %b", n, bus4.o, (n == 7));
            end
        end
        apply_reset();
        ce_pat = 11'b10101010101;
        i_pat  = 11'b11101111111;
        for (int n = 10; n >= 0; n--) begin
            tick(ce_pat[n], i_pat[n]);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs(k) !== expv(k)) begin
                    miscompares++;
                    $display("FAIL ce_bounce dut%0d cyc%0d: got %b required %b", k, cyc, obs(k), expv(k));
                end
            end
            if (n == 2 || n == 0) begin
                vectors++;
                if (bus4.o !== (n == 0)) begin
                    miscompares++;
                    $display("FAIL ce_bounce_restart n=%0d: got o=%b required %b", n, bus4.o, (n == 0));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int n = 0; n < 10; n++) tick(1'b1, (n < 4) || (n >= 8));
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs(k) !== expv(k)) begin
                miscompares++;
                $display("FAIL async_reset dut%0d: got %b required %b", k, obs(k), expv(k));
            end
        end
        @(negedge c);
        rst_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick(1'b1, 1'b1);
            vectors++;
            if (obs(0) !== expv(0) || bus4.rise !== (n == 4)) begin
                miscompares++;
                $display("FAIL async_restart n=%0d: got %b required %b", n, obs(0), expv(0));
            end
        end
    endtask

    task automatic test_wrap();
        logic lvl;
        lvl = 1'b0;
        apply_reset();
        for (int t = 1; t <= 16; t++) begin
            lvl = ~lvl;
            for (int n = 0; n < 4; n++) tick(1'b1, lvl);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs(k) !== expv(k)) begin
                    miscompares++;
                    $display("FAIL wrap dut%0d t=%0d: got %b required %b", k, t, obs(k), expv(k));
                end
            end
            if (t >= 15) begin
                vectors++;
                if (bus4.edges !== ((t == 15) ? 4'd15 : 4'd0)) begin
                    miscompares++;
                    $display("FAIL wrap_edges t=%0d: got %0d", t, bus4.edges);
                end
            end
        end
    endtask

    task automatic test_hold1();
        logic prev;
        logic cur;
        prev = 1'b0;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            cur = 1'($urandom_range(0, 1));
            tick(1'b1, cur);
            vectors++;
            if ({bus1.o, bus1.rise, bus1.fall} !== {cur, cur & ~prev, ~cur & prev} || obs(1) !== expv(1)) begin
                miscompares++;
                $display("FAIL hold1 cyc%0d: got o/r/f=%b%b%b i=%b prev=%b", cyc, bus1.o, bus1.rise, bus1.fall, cur, prev);
            end
            prev = cur;
        end
    endtask

    task automatic test_random();
        logic lvl;
        lvl = 1'b0;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) lvl = ~lvl;
            tick($urandom_range(0, 3) != 0, lvl);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs(k) !== expv(k)) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc%0d: got %b required %b", k, cyc, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_ce();
        test_async_reset();
        test_wrap();
        test_hold1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
